// File: rtl/leaf_stream_packer_if.sv
// Beat/word bundle for leaf_stream_packer: narrow input stream in, packed words out.
// Latency: none, wires only.
// Backpressure: carries in_ready/out_ready; optional out_parity when PACKER_PARITY_EN is defined.
interface leaf_stream_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]      out_keep;
  logic                  out_last;
`ifdef PACKER_PARITY_EN
  logic [RATIO-1:0]      out_parity;

  // Environment side: produces beats, consumes packed words.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, out_parity
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, out_parity
  );
`else
  // Environment side: produces beats, consumes packed words.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
`endif
endinterface

// File: rtl/leaf_stream_packer.sv
// Purpose: packs RATIO IN_W-bit beats (first beat in LSBs) into one word; in_last closes short words with out_keep marking real lanes; saturating packet counter.
// Latency: word is registered one cycle after its completing beat is accepted; one beat per cycle, no bubble at word boundaries.
// Backpressure: in_ready = ~out_valid | out_ready, so a held word stalls all input. Optional per-lane out_parity under PACKER_PARITY_EN.
module leaf_stream_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  leaf_stream_packer_if.slave  bus,
  output logic [CNT_W-1:0]     pkt_count
);

  localparam int                LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int                OUT_W     = IN_W * RATIO;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FILL  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LANE_W-1:0] lane;
  logic [LANE_W-1:0] lane_nxt;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  acc_nxt;
  logic [RATIO-1:0]  keep;
  logic [RATIO-1:0]  keep_nxt;

  // Accumulator contents with the current beat already dropped into its lane.
  logic [OUT_W-1:0]  merged;
  logic [RATIO-1:0]  merged_keep;

  logic              in_ready_w;
  logic              beat_acc;
  logic              complete;

  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [RATIO-1:0]  out_keep_q;
  logic              out_last_q;

  // The stage is free whenever the output slot is empty or being drained this cycle.
  assign in_ready_w = ~out_valid_q | bus.out_ready;
  assign beat_acc   = bus.in_valid & in_ready_w;
  assign complete   = beat_acc & ((lane == LAST_LANE) | bus.in_last);

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_keep  = out_keep_q;
  assign bus.out_last  = out_last_q;

  // Overlay the incoming beat onto the current lane; lanes not yet written stay zero.
  always_comb begin
    merged      = acc;
    merged_keep = keep;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == LANE_W'(i)) begin
        merged[i*IN_W +: IN_W] = bus.in_data;
        merged_keep[i]         = 1'b1;
      end
    end
  end

  // Next-state: a completing beat empties the accumulator, any other accepted beat advances the lane.
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    acc_nxt   = acc;
    keep_nxt  = keep;
    case (state)
      S_EMPTY: begin
        if (beat_acc) begin
          if (complete) begin
            state_nxt = S_EMPTY;
            lane_nxt  = '0;
            acc_nxt   = '0;
            keep_nxt  = '0;
          end else begin
            state_nxt = S_FILL;
            lane_nxt  = LANE_W'(1);
            acc_nxt   = merged;
            keep_nxt  = merged_keep;
          end
        end
      end
      S_FILL: begin
        if (beat_acc) begin
          if (complete) begin
            state_nxt = S_EMPTY;
            lane_nxt  = '0;
            acc_nxt   = '0;
            keep_nxt  = '0;
          end else begin
            lane_nxt  = lane + LANE_W'(1);
            acc_nxt   = merged;
            keep_nxt  = merged_keep;
          end
        end
      end
      default: begin
        state_nxt = S_EMPTY;
        lane_nxt  = '0;
        acc_nxt   = '0;
        keep_nxt  = '0;
      end
    endcase
  end

  // State, lane index and partial-word accumulator; reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      lane  <= '0;
      acc   <= '0;
      keep  <= '0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
      acc   <= acc_nxt;
      keep  <= keep_nxt;
    end
  end

  // Output slot: a new word always wins, even on the edge the old one is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      out_data_q  <= merged;
      out_keep_q  <= merged_keep;
      out_last_q  <= bus.in_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Packets are counted when their closing word is loaded, not when it leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (complete && bus.in_last && (pkt_count != {CNT_W{1'b1}})) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

`ifdef PACKER_PARITY_EN
  logic [RATIO-1:0] merged_par;
  logic [RATIO-1:0] out_parity_q;

  assign bus.out_parity = out_parity_q;

  // Per-lane XOR of the outgoing word; empty lanes are zero so their parity is zero.
  always_comb begin
    merged_par = '0;
    for (int i = 0; i < RATIO; i++) begin
      merged_par[i] = ^merged[i*IN_W +: IN_W];
    end
  end

  // Parity travels with out_data and is loaded on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity_q <= '0;
    end else if (complete) begin
      out_parity_q <= merged_par;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_stream_packer.sv
// Directed bench for leaf_stream_packer with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge.
// Covers reset, full/short words, back-to-back streaming, stall, mid-word reset, optional parity.
module tb_leaf_stream_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  leaf_stream_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

  leaf_stream_packer #(
    .IN_W  (IN_W),
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat and let it cross one rising edge.
  task automatic beat(input logic [7:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_keep",  bus.out_keep,  0);
    check("rst_out_last",  bus.out_last,  0);
    check("rst_pkt_count", pkt_count,     0);
    check("rst_in_ready",  bus.in_ready,  1);
`ifdef PACKER_PARITY_EN
    check("rst_out_parity", bus.out_parity, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Full word closed by in_last on the last lane.
    beat(8'h11, 1'b0);
    check("t1_no_word_yet", bus.out_valid, 0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    check("t1_still_empty", bus.out_valid, 0);
    beat(8'h44, 1'b1);
    idle();
    check("t1_valid", bus.out_valid, 1);
    check("t1_data",  bus.out_data,  64'h44332211);
    check("t1_keep",  bus.out_keep,  4'b1111);
    check("t1_last",  bus.out_last,  1);
    check("t1_pkt",   pkt_count,     1);
    @(negedge clk);
    check("t1_drained", bus.out_valid, 0);

    // Short word.
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    idle();
    check("t2_valid", bus.out_valid, 1);
    check("t2_data",  bus.out_data,  64'h0000BBAA);
    check("t2_keep",  bus.out_keep,  4'b0011);
    check("t2_last",  bus.out_last,  1);
    check("t2_pkt",   pkt_count,     2);
    @(negedge clk);

    // Eight back-to-back beats, two full words, no in_last.
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(k + 1);
      bus.in_last  = 1'b0;
      check("t3_in_ready", bus.in_ready, 1);
      @(negedge clk);
      if (k == 3) begin
        check("t3_w0_valid", bus.out_valid, 1);
        check("t3_w0_data",  bus.out_data,  64'h04030201);
        check("t3_w0_keep",  bus.out_keep,  4'b1111);
        check("t3_w0_last",  bus.out_last,  0);
      end
      if (k == 4) check("t3_gap_valid", bus.out_valid, 0);
      if (k == 7) begin
        check("t3_w1_valid", bus.out_valid, 1);
        check("t3_w1_data",  bus.out_data,  64'h08070605);
        check("t3_w1_last",  bus.out_last,  0);
      end
    end
    idle();
    check("t3_pkt", pkt_count, 2);
    @(negedge clk);

    // Stall: word held with out_ready low, offered beat must not be taken.
    bus.out_ready = 1'b0;
    beat(8'h21, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h23, 1'b0);
    beat(8'h24, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    bus.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("t4_stall_in_ready", bus.in_ready,  0);
      check("t4_stall_valid",    bus.out_valid, 1);
      check("t4_stall_data",     bus.out_data,  64'h24232221);
      check("t4_stall_last",     bus.out_last,  0);
      @(negedge clk);
    end
    idle();
    bus.out_ready = 1'b1;
    #1;
    check("t4_release_in_ready", bus.in_ready, 1);
    @(negedge clk);
    check("t4_release_valid", bus.out_valid, 0);
    check("t4_pkt_unchanged", pkt_count,     2);
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b1);
    check("t4_next_data", bus.out_data, 64'h0000A2A1);
    check("t4_next_keep", bus.out_keep, 4'b0011);
    check("t4_next_pkt",  pkt_count,    3);

    // Single-beat packets, each loaded on the edge the previous word leaves.
    beat(8'h7E, 1'b1);
    check("t5_a_valid", bus.out_valid, 1);
    check("t5_a_data",  bus.out_data,  64'h0000007E);
    check("t5_a_keep",  bus.out_keep,  4'b0001);
    check("t5_a_last",  bus.out_last,  1);
    beat(8'h5A, 1'b1);
    idle();
    check("t5_b_valid", bus.out_valid, 1);
    check("t5_b_data",  bus.out_data,  64'h0000005A);
    check("t5_b_pkt",   pkt_count,     5);
    @(negedge clk);
    check("t5_drained", bus.out_valid, 0);

    // Reset in the middle of a word.
    beat(8'hE1, 1'b0);
    beat(8'hE2, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",    bus.out_valid, 0);
    check("t6_rst_pkt",      pkt_count,     0);
    check("t6_rst_in_ready", bus.in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(8'h55, 1'b0);
    beat(8'h56, 1'b0);
    beat(8'h57, 1'b0);
    beat(8'h58, 1'b0);
    idle();
    check("t6_valid", bus.out_valid, 1);
    check("t6_data",  bus.out_data,  64'h58575655);
    check("t6_keep",  bus.out_keep,  4'b1111);
    check("t6_last",  bus.out_last,  0);
    check("t6_pkt",   pkt_count,     0);
    @(negedge clk);

`ifdef PACKER_PARITY_EN
    beat(8'h01, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h07, 1'b0);
    beat(8'hFF, 1'b1);
    idle();
    check("t7_data",   bus.out_data,   64'hFF070301);
    check("t7_parity", bus.out_parity, 4'b0101);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_stream_packer.md
Name: leaf_stream_packer

Overview:
- Leaf-level sequential stage for the generated module hierarchy; one instance sits under each leaf instance slot.
- Consumes a narrow valid/ready byte stream and packs RATIO consecutive beats into one wide word for the downstream consumer.
- Handles short final words on `in_last`, marking the valid lanes with `out_keep`.
- Provides a saturating packet counter for hierarchy-level observability.

Parameters:
- IN_W, 8, input beat width in bits.
- RATIO, 4, input beats per output word; must be ≥2.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage accepts a beat this cycle.
- in_data  input  IN_W  beat payload.
- in_last  input  1  beat is the final beat of a packet.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  IN_W*RATIO  packed word.
- out_keep  output  RATIO  one bit per lane; 1 = lane holds a real beat.
- out_last  output  1  word closes a packet.
- pkt_count  output  CNT_W  completed packets; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n low): clears all state.
  - Outputs: out_valid=0, out_data=0, out_keep=0, out_last=0, pkt_count=0.
  - Internal: accumulator=0, lane index=0, FSM=EMPTY.
  - in_ready during reset reads 1 per its equation, but no beat is accepted while rst_n is low.
  - Reset mid-word discards any partial accumulation; nothing is emitted for it.
- Beat handshake: accepted on a rising edge when in_valid & in_ready.
- in_ready = ~out_valid | out_ready. It is combinational and does not depend on in_valid.
- Lane packing:
  - An accepted beat is written into accumulator lane `lane` at bits [lane*IN_W +: IN_W], little-endian (first beat in the LSBs).
  - The lane's keep bit is set.
- FSM:
  - EMPTY: lane=0, accumulator and keep cleared.
    - Accepted beat with a completion condition → transfer; stay EMPTY.
    - Accepted beat otherwise → FILL, lane=1.
  - FILL: each accepted beat writes its lane and lane increments.
    - Completion condition → transfer; return to EMPTY.
- Completion condition: lane==RATIO-1 OR in_last=1.
- Transfer, performed on the same edge as the completing beat's acceptance:
  - out_data = accumulator including the current beat; unfilled lanes are driven 0.
  - out_keep = keep bits; out_last = in_last; out_valid=1.
  - Accumulator and keep are cleared and lane returns to 0.
- Latency: a word appears on out_valid one cycle after its completing beat is accepted.
- Throughput: one beat per cycle with out_ready held high. No bubble at word boundaries.
- Output register:
  - Holds out_data, out_keep and out_last stable while out_valid & ~out_ready.
  - out_valid clears on out_ready unless a new transfer occurs on the same edge.
  - Simultaneous out_ready handshake and new transfer: the new word replaces the old one and out_valid stays 1.
- Backpressure: while out_valid & ~out_ready, in_ready=0, so no beats are accepted, including non-completing beats.
- in_last on lane RATIO-1: a single word with all keep bits set and out_last=1.
- in_last on the first beat: out_keep = 0…01.
- pkt_count: increments by 1 on each transfer with out_last=1, i.e. on the edge where the word is loaded, not on the downstream handshake. Holds at 2^CNT_W-1.

Optional Feature:
- Macro: PACKER_PARITY_EN.
- Defined:
  - Adds output port `out_parity`, width RATIO, registered with out_data.
  - Bit i = XOR reduction of lane i. Unfilled lanes give parity 0.
  - Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 beats 0x11,0x22,0x33,0x44 (in_last on the 4th), out_ready=1 → one cycle later out_data=0x44332211, out_keep=4'b1111, out_last=1, pkt_count=1.
- Beats 0xAA,0xBB with in_last on 0xBB → out_data=0x0000BBAA, out_keep=4'b0011, out_last=1.
- 8 back-to-back beats 0x01..0x08 without in_last, out_ready=1 → two consecutive words 0x04030201 then 0x08070605, out_last=0, in_ready held 1 throughout.
- First word pending with out_ready=0 for 5 cycles → in_ready=0, out_data stable for 5 cycles. Then out_ready=1 → handshake completes and in_ready=1 in the same cycle.
- rst_n pulsed low after 2 beats of a word, then 4 new beats 0x55..0x58 → first output is 0x58575655; no stale lanes.
- With PACKER_PARITY_EN, beats 0x01,0x03,0x07,0xFF → out_parity=4'b0101.
